// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request and writes the F/D register.
// Handles variable-latency responses, stalls, branch redirects and HLT.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic        fd_wen,
  output logic [15:0] instruction_out,
  output logic [15:0] oldPC_out,
  output logic [15:0] newPC_out,
  output logic        halt_out
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam logic [15:0] NOP    = 16'h0000;
  localparam logic [3:0]  HLT_OP = 4'hF;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] stale_q, stale_d;
  logic [15:0] pc_inc;
  logic        is_hlt;
  logic        req_c;
  logic [15:0] addr_c;
  logic        wen_c;
  logic [15:0] instr_c;
  logic        halt_c;

  assign pc_inc = pc_q + 16'd2;
  assign is_hlt = (imem_rdata[15:12] == HLT_OP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= 16'h0000;
      stale_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    req_c   = (state_q != S_HALTED);
    // While draining, the memory still owns the old address; keep presenting it.
    addr_c  = (state_q == S_DRAIN) ? stale_q : pc_q;
    wen_c   = 1'b0;
    instr_c = NOP;
    halt_c  = 1'b0;

    if (branch_taken) begin
      wen_c = 1'b1;
      pc_d  = branch_target;
      if (req_c && !imem_valid) begin
        state_d = S_DRAIN;
        if (state_q != S_DRAIN) begin
          stale_d = pc_q;
        end
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            if (!stall) begin
              wen_c   = 1'b1;
              instr_c = imem_rdata;
              if (is_hlt) begin
                halt_c  = 1'b1;
                state_d = S_HALTED;
              end else begin
                pc_d = pc_inc;
              end
            end
          end else begin
            wen_c = !stall;
          end
        end
        S_DRAIN: begin
          wen_c = !stall;
          if (imem_valid) begin
            state_d = S_FETCH;
          end
        end
        S_HALTED: begin
          wen_c = 1'b0;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // Reset gates the outputs combinationally so they are quiet the instant rst falls.
  assign imem_req        = rst & req_c;
  assign imem_addr       = addr_c;
  assign fd_wen          = rst & wen_c;
  assign instruction_out = rst ? instr_c : NOP;
  assign halt_out        = rst & halt_c;
  assign oldPC_out       = pc_q;
  assign newPC_out       = pc_inc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory model, cycle-by-cycle behavioural
// reference, directed scenarios with literal expectations and a randomized run.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        fd_wen;
  logic [15:0] instruction_out;
  logic [15:0] oldPC_out;
  logic [15:0] newPC_out;
  logic        halt_out;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_valid      (imem_valid),
    .fd_wen          (fd_wen),
    .instruction_out (instruction_out),
    .oldPC_out       (oldPC_out),
    .newPC_out       (newPC_out),
    .halt_out        (halt_out)
  );

  int checks = 0;
  int errors = 0;

  // Memory: a request held for L cycles answers in its L-th cycle (L=1 answers at once).
  logic [15:0] mem [0:65535];
  int unsigned wait_cnt;
  int unsigned cur_lat;
  int unsigned fixed_lat;
  bit          rand_lat;

  always_comb imem_valid = rst && imem_req &&
                           ((wait_cnt + 1) >= (rand_lat ? cur_lat : fixed_lat));
  always_comb imem_rdata = mem[imem_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 0;
      cur_lat  <= $urandom_range(1, 4);
    end else if (imem_req) begin
      if (imem_valid) begin
        wait_cnt <= 0;
        cur_lat  <= $urandom_range(1, 4);
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Reference model: mode 0 = fetching, 1 = waiting out a squashed request, 2 = halted.
  int          m_mode = 0;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_stale = 16'h0000;

  always @(negedge clk) begin : cmp
    logic        e_req, e_wen, e_halt, ok, outstanding;
    logic [15:0] e_addr, e_ins, e_old, e_new;
    e_old = m_pc;
    e_new = m_pc + 16'd2;
    e_ins = 16'h0000;
    e_halt = 1'b0;
    e_wen = 1'b0;
    if (!rst) begin
      m_mode = 0;
      m_pc = 16'h0000;
      e_req = 1'b0;
      e_addr = 16'h0000;
      e_old = 16'h0000;
      e_new = 16'h0002;
    end else begin
      e_req = (m_mode != 2);
      e_addr = (m_mode == 1) ? m_stale : m_pc;
      outstanding = e_req && !imem_valid;
      if (branch_taken) begin
        e_wen = 1'b1;
        if (outstanding) begin
          if (m_mode != 1) m_stale = m_pc;
          m_mode = 1;
        end else begin
          m_mode = 0;
        end
        m_pc = branch_target;
      end else if (m_mode == 2) begin
        e_wen = 1'b0;
      end else if (m_mode == 1) begin
        e_wen = !stall;
        if (imem_valid) m_mode = 0;
      end else if (!imem_valid) begin
        e_wen = !stall;
      end else if (!stall) begin
        e_wen = 1'b1;
        e_ins = imem_rdata;
        if (imem_rdata >= 16'hF000) begin
          e_halt = 1'b1;
          m_mode = 2;
        end else begin
          m_pc = m_pc + 16'd2;
        end
      end
    end
    ok = (imem_req === e_req) && (!e_req || imem_addr === e_addr) && (fd_wen === e_wen);
    if (e_wen || !rst)
      ok = ok && (instruction_out === e_ins) && (halt_out === e_halt) &&
           (oldPC_out === e_old) && (newPC_out === e_new);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model_cmp t=%0t got/exp req=%b/%b addr=%h/%h wen=%b/%b ins=%h/%h halt=%b/%b old=%h/%h new=%h/%h",
               $time, imem_req, e_req, imem_addr, e_addr, fd_wen, e_wen, instruction_out, e_ins,
               halt_out, e_halt, oldPC_out, e_old, newPC_out, e_new);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 16'h0000;
    fixed_lat = 1;
    rand_lat = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 15) == 0) w[15:12] = 4'hF;
      else if (w[15:12] == 4'hF) w[15:12] = 4'h3;
      mem[i] = w;
    end
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'h5678;
    mem[16'h0010] = 16'h1A2B;
    mem[16'h0020] = 16'hF000;
    mem[16'h0040] = 16'h4321;
    mem[16'h0100] = 16'h0ABC;
    mem[16'hFFFE] = 16'h7777;

    // Reset release, single-cycle memory: back-to-back writes
    do_reset();
    #2 chk("first_req", {15'b0, imem_req}, 16'h0001);
    chk("first_addr", imem_addr, 16'h0000);
    chk("first_ins", instruction_out, 16'h1234);
    chk("first_old", oldPC_out, 16'h0000);
    chk("first_new", newPC_out, 16'h0002);
    tick();
    #2 chk("second_wen", {15'b0, fd_wen}, 16'h0001);
    chk("second_ins", instruction_out, 16'h5678);
    chk("second_old", oldPC_out, 16'h0002);
    chk("second_new", newPC_out, 16'h0004);

    // Latency 3 at 0x0010: two bubbles then the instruction
    do_reset();
    branch_taken = 1'b1;
    branch_target = 16'h0010;
    #2 chk("br10_ins", instruction_out, 16'h0000);
    tick();
    branch_taken = 1'b0;
    fixed_lat = 3;
    for (int k = 0; k < 2; k++) begin
      #2 chk("lat3_bubble_wen", {15'b0, fd_wen}, 16'h0001);
      chk("lat3_bubble_ins", instruction_out, 16'h0000);
      chk("lat3_addr", imem_addr, 16'h0010);
      tick();
    end
    #2 chk("lat3_ins", instruction_out, 16'h1A2B);
    chk("lat3_old", oldPC_out, 16'h0010);
    fixed_lat = 1;

    // Two stall cycles during valid responses
    do_reset();
    tick();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2 chk("stall_wen", {15'b0, fd_wen}, 16'h0000);
      chk("stall_addr", imem_addr, 16'h0002);
      tick();
    end
    stall = 1'b0;
    #2 chk("resume_ins", instruction_out, 16'h5678);
    chk("resume_old", oldPC_out, 16'h0002);

    // Branch while a latency-4 request is outstanding
    do_reset();
    tick();
    fixed_lat = 4;
    branch_taken = 1'b1;
    branch_target = 16'h0100;
    #2 chk("drain_br_wen", {15'b0, fd_wen}, 16'h0001);
    chk("drain_br_ins", instruction_out, 16'h0000);
    tick();
    branch_taken = 1'b0;
    #2 chk("drain_stale_addr", imem_addr, 16'h0002);
    tick();
    tick();
    #2 chk("drain_drop_ins", instruction_out, 16'h0000);
    chk("drain_drop_wen", {15'b0, fd_wen}, 16'h0001);
    tick();
    #2 chk("drain_new_addr", imem_addr, 16'h0100);
    chk("drain_new_req", {15'b0, imem_req}, 16'h0001);
    fixed_lat = 1;

    // HLT at 0x0020, then branch out of HALTED
    do_reset();
    branch_taken = 1'b1;
    branch_target = 16'h0020;
    tick();
    branch_taken = 1'b0;
    #2 chk("hlt_halt", {15'b0, halt_out}, 16'h0001);
    chk("hlt_ins", instruction_out, 16'hF000);
    chk("hlt_wen", {15'b0, fd_wen}, 16'h0001);
    for (int k = 0; k < 2; k++) begin
      tick();
      #2 chk("halted_req", {15'b0, imem_req}, 16'h0000);
      chk("halted_wen", {15'b0, fd_wen}, 16'h0000);
    end
    tick();
    branch_taken = 1'b1;
    branch_target = 16'h0040;
    #2 chk("unhalt_wen", {15'b0, fd_wen}, 16'h0001);
    chk("unhalt_halt", {15'b0, halt_out}, 16'h0000);
    tick();
    branch_taken = 1'b0;
    #2 chk("unhalt_addr", imem_addr, 16'h0040);
    chk("unhalt_ins", instruction_out, 16'h4321);

    // PC wrap at 0xFFFE, then asynchronous reset mid-latency
    do_reset();
    branch_taken = 1'b1;
    branch_target = 16'hFFFE;
    tick();
    branch_taken = 1'b0;
    #2 chk("wrap_old", oldPC_out, 16'hFFFE);
    chk("wrap_new", newPC_out, 16'h0000);
    tick();
    #2 chk("wrap_addr", imem_addr, 16'h0000);
    tick();
    fixed_lat = 3;
    #2 chk("pre_rst_addr", imem_addr, 16'h0002);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("async_rst_wen", {15'b0, fd_wen}, 16'h0000);
    chk("async_rst_pc", oldPC_out, 16'h0000);
    chk("async_rst_req", {15'b0, imem_req}, 16'h0000);
    chk("async_rst_new", newPC_out, 16'h0002);
    fixed_lat = 1;

    // Randomized traffic with random latency, stalls, branches and occasional resets
    rand_lat = 1'b1;
    do_reset();
    for (int c = 1; c <= 3000; c++) begin
      tick();
      if (c % 700 == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      stall = ($urandom_range(0, 99) < 25);
      branch_taken = !branch_taken && ($urandom_range(0, 99) < 8);
      branch_target = 16'($urandom) & 16'hFFFE;
    end
    tick();
    branch_taken = 1'b0;
    stall = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
